// File: rtl/cnorm_pkg.sv
// rtl/cnorm_pkg.sv - shared types, shift codes and headroom function for cnorm_shift_ctrl
package cnorm_pkg;

  localparam int CNORM_FRAME = 64;

  function automatic int cnt_width(input int frame);
    return (frame > 1) ? $clog2(frame) : 1;
  endfunction

  localparam int CNORM_CNT_W = cnt_width(CNORM_FRAME);

  // SHIFT code: number of redundant sign bits CNORM drops before keeping [nb+2:1]
  localparam logic [1:0] SH_NONE      = 2'd0;
  localparam logic [1:0] SH_GUARD_MAX = 2'd2;
  localparam logic [1:0] SH_MAX       = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  // top = sample bits [nb+2:nb-1]; returns how many bits below the sign repeat it
  function automatic logic [1:0] headroom(input logic [3:0] top);
    if (top[3] != top[2]) return 2'd0;
    if (top[2] != top[1]) return 2'd1;
    if (top[1] != top[0]) return 2'd2;
    return SH_MAX;
  endfunction

endpackage

// File: rtl/cnorm_headroom.sv
// rtl/cnorm_headroom.sv - combinational redundant-sign-bit count (0..3) of one nb+3 bit sample
module cnorm_headroom
  import cnorm_pkg::*;
#(
  parameter int nb = 16
) (
  input  logic [nb+2:0] i_sample,
  output logic [1:0]    o_h
);

  logic w_unused;

  assign o_h      = headroom(i_sample[nb+2:nb-1]);
  assign w_unused = ^i_sample[nb-2:0];

endmodule

// File: rtl/cnorm_shift_ctrl.sv
// rtl/cnorm_shift_ctrl.sv - block-floating-point SHIFT scheduler for CNORM (option: CNORM_SAT_GUARD_EN)
module cnorm_shift_ctrl
  import cnorm_pkg::*;
#(
  parameter int nb    = 16,
  parameter int FRAME = CNORM_FRAME,
  parameter int EW    = 6
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 ED,
  input  logic                 CLR,
  input  logic                 START,
  input  logic [nb+2:0]        DR,
  input  logic [nb+2:0]        DI,
  input  logic                 APPLY,
  input  logic                 CN_OVF,
  input  logic                 CN_RDY,
  output logic [1:0]           SHIFT,
  output logic                 CN_START,
  output logic                 RDY,
  output logic signed [EW-1:0] EXP,
  output logic                 OVF,
  output logic                 ERR
);

  localparam int            CW   = cnt_width(FRAME);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  logic [1:0]    w_hr, w_hi, w_h, w_hmin_nx, w_pend_src, w_shift_eff;
  logic          w_done, w_have, w_cn_start, w_ovf_evt;
  scan_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_hmin, r_pend, r_shift;
  logic          r_rdy, r_cn_start, r_mon, r_ovf, r_err;
  logic [EW-1:0] r_exp;

  cnorm_headroom #(.nb(nb)) u_hr_re (.i_sample(DR), .o_h(w_hr));
  cnorm_headroom #(.nb(nb)) u_hr_im (.i_sample(DI), .o_h(w_hi));

  always_comb begin
    w_h        = (w_hr < w_hi) ? w_hr : w_hi;
    w_hmin_nx  = (w_h < r_hmin) ? w_h : r_hmin;
    w_done     = ED && !START && (r_state == ST_SCAN) && (r_cnt == LAST);
    w_have     = w_done || r_rdy;
    w_pend_src = w_done ? w_hmin_nx : r_pend;
    w_cn_start = r_cn_start && ED;
    // monitor window opens on CN_RDY and closes when the next CN_START goes out
    w_ovf_evt  = ED && CN_OVF && (CN_RDY || (r_mon && !r_cn_start));
  end

`ifdef CNORM_SAT_GUARD_EN
  logic       r_ovf_prev;
  logic [1:0] w_cap;

  always_comb begin
    w_cap       = !w_have ? SH_NONE : ((w_pend_src > SH_GUARD_MAX) ? SH_GUARD_MAX : w_pend_src);
    w_shift_eff = (r_ovf_prev && (w_cap != SH_NONE)) ? (w_cap - 2'd1) : w_cap;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ovf_prev <= 1'b0;
    end else if (ED) begin
      if (CLR)            r_ovf_prev <= 1'b0;
      else if (APPLY)     r_ovf_prev <= w_ovf_evt;
      else if (w_ovf_evt) r_ovf_prev <= 1'b1;
    end
  end
`else
  assign w_shift_eff = w_have ? w_pend_src : SH_NONE;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_hmin     <= '0;
      r_pend     <= '0;
      r_shift    <= '0;
      r_rdy      <= 1'b0;
      r_cn_start <= 1'b0;
      r_mon      <= 1'b0;
      r_ovf      <= 1'b0;
      r_err      <= 1'b0;
      r_exp      <= '0;
    end else if (ED) begin
      r_cn_start <= 1'b0;
      if (CN_RDY)          r_mon <= 1'b1;
      else if (r_cn_start) r_mon <= 1'b0;
      if (w_ovf_evt)       r_ovf <= 1'b1;

      if (CLR) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_hmin  <= '0;
        r_pend  <= '0;
        r_rdy   <= 1'b0;
        r_mon   <= 1'b0;
        r_ovf   <= 1'b0;
        r_err   <= 1'b0;
        r_exp   <= '0;
      end else begin
        if (START) begin
          if (r_state == ST_SCAN) r_err <= 1'b1;
          r_hmin  <= w_h;
          r_cnt   <= CW'(1);
          r_state <= ST_SCAN;
        end else if (r_state == ST_SCAN) begin
          r_hmin <= w_hmin_nx;
          r_cnt  <= r_cnt + CW'(1);
          if (w_done) begin
            r_pend  <= w_hmin_nx;
            r_state <= ST_IDLE;
          end
        end

        if (APPLY) begin
          r_shift    <= w_shift_eff;
          r_cn_start <= 1'b1;
          r_rdy      <= 1'b0;
          r_exp      <= r_exp + EW'(1) - EW'(w_shift_eff);
          if (!w_have) r_err <= 1'b1;
        end else if (w_done) begin
          r_rdy <= 1'b1;
          if (r_rdy) r_err <= 1'b1;
        end
      end
    end
  end

  assign SHIFT    = r_shift;
  assign CN_START = w_cn_start;
  assign RDY      = r_rdy;
  assign EXP      = r_exp;
  assign OVF      = r_ovf;
  assign ERR      = r_err;

endmodule

// File: doc/cnorm_shift_ctrl.md
Name: cnorm_shift_ctrl

Overview:
Block-floating-point scheduler for the CNORM normalization unit in the FFT64 stage datapath.
- Scans one frame of stage outputs and measures the common headroom (redundant sign bits) over all re/im samples.
- Selects the 2-bit SHIFT code for the pass of that frame through CNORM, issues CNORM's START, and checks CNORM's OVF.
- Keeps a running block exponent for the whole transform.

Parameters:
nb, 16, data width parameter from `USFFT64paramnb`; samples are nb+3 bits.
FRAME, 64, samples per frame; a power of 2.
EW, 6, block exponent width (signed).

Ports:
CLK  in  1  clock, rising edge.
RST_N  in  1  asynchronous active-low reset.
ED  in  1  enable; state advances only on cycles with ED=1.
CLR  in  1  start of a new transform; clears EXP, OVF, ERR and the pending register.
START  in  1  scan side: first sample of a frame.
DR  in  nb+3  scan sample, real part, two's complement.
DI  in  nb+3  scan sample, imaginary part, two's complement.
APPLY  in  1  apply side: the scanned frame starts streaming into CNORM.
CN_OVF  in  1  OVF output of CNORM.
CN_RDY  in  1  RDY output of CNORM.
SHIFT  out  2  shift code to CNORM, held for a whole frame.
CN_START  out  1  START pulse to CNORM.
RDY  out  1  pending shift valid.
EXP  out  EW  accumulated block exponent (signed).
OVF  out  1  sticky overflow flag.
ERR  out  1  sticky sequencing error.

Behaviour:
Reset:
- All outputs and state go to 0 asynchronously; FSM goes to IDLE.
- Reset in the middle of a frame drops that frame; no partial result is kept.

Per-sample headroom h (0..3), computed for each of DR and DI:
- h=0 if bit nb+2 != bit nb+1.
- h=1 if bits nb+2..nb+1 are equal and bit nb differs.
- h=2 if bits nb+2..nb are equal and bit nb-1 differs.
- h=3 if bits nb+2..nb-1 are all equal.
- Frame headroom = minimum of h over both parts of all FRAME samples.

Scan FSM, states IDLE and SCAN:
- IDLE: on START&ED, load hmin with this sample's h, set cnt=1, go to SCAN.
- SCAN: on each ED cycle, hmin <= min(hmin, h) and cnt increments.
- On the sample with cnt=FRAME-1: write the final min into PEND, set RDY=1, go to IDLE.
- START in SCAN restarts the frame (cnt=1, hmin reloaded) and sets ERR.
- START on the cycle just after the last sample is legal; frames run back to back with no gap.

Apply, on APPLY&ED:
- Registered, 1-cycle latency: SHIFT <= PEND, CN_START=1 for one ED cycle, RDY <= 0.
- With EXP: EXP <= EXP + 1 - PEND. CNORM keeps bits [nb+2:1] after the shift, so the net gain is 2^(SHIFT-1).
- If PEND is written on the same cycle, APPLY bypasses and takes the new value.
- APPLY with RDY=0 and no write that cycle: SHIFT <= 0 (no gain, safe) and ERR <= 1.
- If the scan completes while RDY=1 and no APPLY occurs that cycle, PEND is overwritten and ERR <= 1.

Overflow check:
- Starts on CN_RDY, the cycle after CN_START.
- Until the next CN_START, CN_OVF=1 on any ED cycle sets OVF (sticky).
- OVF is cleared only by CLR or reset.

CLR:
- Synchronous, needs ED=1, takes priority over same-cycle APPLY/START.
- FSM goes to IDLE; EXP, OVF, ERR, RDY, PEND are cleared; SHIFT is kept.

Signals are used as delivered, with no internal re-timing. ED=0 freezes all state, with CN_START held low.

Optional Feature:
CNORM_SAT_GUARD_EN
- Defined: the applied shift is min(PEND, 2), so up to one extra guard bit is kept.
  - Also, if OVF was set by the previous frame, the next applied shift is reduced by 1 (floored at 0).
- Not defined: the applied shift equals PEND exactly.

Decomposition:
- Shared package cnorm_pkg: the headroom function, SHIFT code encoding, FSM state encoding, and a FRAME counter width equal to clog2(FRAME).
- One sub-module, cnorm_headroom: combinational h for one nb+3 sample, instanced once for DR and once for DI.

Test Plan:
(nb=16, FRAME=64, samples 19-bit hex)
- 64 samples DR=DI=19'h00100, then APPLY → RDY=1 after sample 63; SHIFT=3, CN_START pulses once, EXP=-2.
- Sample 10 has DR=19'h20000, all others 19'h00100 → SHIFT=0, EXP=+1.
- DI=19'h08000 on one sample, DI=19'h10000 on another → SHIFT=1; with CNORM_SAT_GUARD_EN, all-small frame → SHIFT=2.
- APPLY with no frame scanned → SHIFT=0, ERR=1; then CLR → ERR=0, EXP=0.
- CN_OVF=1 for one cycle after CN_RDY → OVF=1, stays 1 across the next frame until CLR; RST_N low in the middle of SCAN → all outputs 0 at once, next START scans cleanly.
